// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the accumulator CPU: the opcode
//            and sequencer-phase enumerations plus default datapath widths.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int CPU_ADDR_W = 5;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Instructions that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_decode
// Purpose  : Combinational strobe decode for the eight-phase sequencer.
// Ports    : phase, opcode, acc_zero, halted in; sel, mem_rd, mem_wr, ld_ir,
//            pc_inc, pc_load, acc_load, data_en, halt out.
// Revision : 1.0  initial release
// ============================================================================
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  phase_t  phase,
    input  opcode_t opcode,
    input  logic    acc_zero,
    input  logic    halted,
    output logic    sel,
    output logic    mem_rd,
    output logic    mem_wr,
    output logic    ld_ir,
    output logic    pc_inc,
    output logic    pc_load,
    output logic    acc_load,
    output logic    data_en,
    output logic    halt
);

    logic w_aluop;
    assign w_aluop = is_aluop(opcode);

    always_comb begin
        sel      = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ld_ir    = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_load = 1'b0;
        data_en  = 1'b0;
        halt     = 1'b0;
        case (phase)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
                ld_ir  = 1'b1;
            end
            PH_OP_ADDR: begin
                // A halted CPU must not keep walking the PC.
                pc_inc = ~halted;
                halt   = halted;
            end
            PH_OP_FETCH: begin
                mem_rd = w_aluop;
            end
            PH_ALU_OP: begin
                mem_rd  = w_aluop;
                pc_inc  = (opcode == OP_SKZ) && acc_zero;
                pc_load = (opcode == OP_JMP);
                data_en = (opcode == OP_STO);
            end
            PH_STORE: begin
                mem_rd   = w_aluop;
                acc_load = w_aluop;
                pc_load  = (opcode == OP_JMP);
                mem_wr   = (opcode == OP_STO);
                data_en  = (opcode == OP_STO);
            end
            default: begin
                sel = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq
// Purpose  : Eight-phase fetch/decode/execute sequencer. Holds the phase
//            counter, instruction register and halt flag; strobes are a
//            combinational decode of that registered state.
// Ports    : clk, rst (async, active-high), en, mem_rdata, acc_zero,
//            [resume]; phase, sel, mem_rd, mem_wr, ld_ir, pc_inc, pc_load,
//            pc_target, acc_load, data_en, halt, opcode.
// Config   : CPU_CTRL_RESUME_EN adds the resume port, letting a halted CPU
//            continue with phase 5; otherwise only rst leaves HALT.
// Revision : 1.0  initial release
// ============================================================================
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              acc_zero,
`ifdef CPU_CTRL_RESUME_EN
    input  logic              resume,
`endif
    output logic [2:0]        phase,
    output logic              sel,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              ld_ir,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              acc_load,
    output logic              data_en,
    output logic              halt,
    output logic [2:0]        opcode
);

    phase_t            r_phase;
    logic [DATA_W-1:0] r_ir;
    logic              r_halted;
    opcode_t           w_opcode;
    phase_t            w_phase_next;

    assign w_opcode     = opcode_t'(r_ir[DATA_W-1:DATA_W-3]);
    assign w_phase_next = phase_t'(3'(r_phase + 3'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else if (en) begin
            if (r_halted) begin
`ifdef CPU_CTRL_RESUME_EN
                // Resuming skips the rest of OP_ADDR so the HLT behaves as a NOP.
                if (resume) begin
                    r_halted <= 1'b0;
                    r_phase  <= PH_OP_FETCH;
                end
`endif
            end else begin
                r_phase <= w_phase_next;
                if (r_phase == PH_INST_LOAD) begin
                    r_ir <= mem_rdata;
                end
                // IR is valid in IDLE, so the halt flag is raised as phase 4 is entered.
                if ((r_phase == PH_IDLE) && (w_opcode == OP_HLT)) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign phase     = r_phase;
    assign opcode    = r_ir[DATA_W-1:DATA_W-3];
    assign pc_target = r_ir[ADDR_W-1:0];

    cpu_ctrl_decode u_decode (
        .phase    (r_phase),
        .opcode   (w_opcode),
        .acc_zero (acc_zero),
        .halted   (r_halted),
        .sel      (sel),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .ld_ir    (ld_ir),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .acc_load (acc_load),
        .data_en  (data_en),
        .halt     (halt)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_seq
// Purpose  : Directed self-checking bench for cpu_ctrl_seq. A behavioural
//            model predicts phase, strobes, target and opcode for each cycle;
//            predictions are queued when stimulus is driven and compared after
//            the clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] mem_rdata;
    logic       acc_zero;
    logic       resume;
    logic [2:0] phase;
    logic       sel, mem_rd, mem_wr, ld_ir, pc_inc, pc_load, acc_load, data_en, halt;
    logic [4:0] pc_target;
    logic [2:0] opcode;

    cpu_ctrl_seq #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mem_rdata (mem_rdata),
        .acc_zero  (acc_zero),
`ifdef CPU_CTRL_RESUME_EN
        .resume    (resume),
`endif
        .phase     (phase),
        .sel       (sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ld_ir     (ld_ir),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .acc_load  (acc_load),
        .data_en   (data_en),
        .halt      (halt),
        .opcode    (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: sel, mem_rd, mem_wr, ld_ir, pc_inc, pc_load, acc_load, data_en, halt
    typedef struct packed {
        logic [2:0] ph;
        logic [8:0] st;
        logic [4:0] tgt;
        logic [2:0] op;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [2:0] m_ph;
    logic [7:0] m_ir;
    logic       m_halt;

    function automatic logic [8:0] exp_strobes(input logic [2:0] ph, input logic [2:0] op,
                                               input logic az, input logic hl);
        logic alu;
        logic s_sel, s_rd, s_wr, s_ld, s_inc, s_load, s_acc, s_den, s_halt;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        {s_sel, s_rd, s_wr, s_ld, s_inc, s_load, s_acc, s_den, s_halt} = 9'b0;
        case (ph)
            3'd0: s_sel = 1'b1;
            3'd1: begin s_sel = 1'b1; s_rd = 1'b1; end
            3'd2, 3'd3: begin s_sel = 1'b1; s_rd = 1'b1; s_ld = 1'b1; end
            3'd4: begin s_inc = ~hl; s_halt = hl; end
            3'd5: s_rd = alu;
            3'd6: begin
                s_rd   = alu;
                s_inc  = (op == 3'd1) && az;
                s_load = (op == 3'd7);
                s_den  = (op == 3'd6);
            end
            default: begin
                s_rd   = alu;
                s_acc  = alu;
                s_load = (op == 3'd7);
                s_wr   = (op == 3'd6);
                s_den  = (op == 3'd6);
            end
        endcase
        return {s_sel, s_rd, s_wr, s_ld, s_inc, s_load, s_acc, s_den, s_halt};
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.ph  = m_ph;
        e.st  = exp_strobes(m_ph, m_ir[7:5], acc_zero, m_halt);
        e.tgt = m_ir[4:0];
        e.op  = m_ir[7:5];
        return e;
    endfunction

    task automatic model_reset();
        m_ph   = 3'd0;
        m_ir   = 8'h00;
        m_halt = 1'b0;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (en) begin
            if (m_halt) begin
`ifdef CPU_CTRL_RESUME_EN
                if (resume) begin
                    m_halt = 1'b0;
                    m_ph   = 3'd5;
                end
`endif
            end else begin
                if (m_ph == 3'd2) m_ir = mem_rdata;
                if (m_ph == 3'd3 && m_ir[7:5] == 3'd0) m_halt = 1'b1;
                m_ph = m_ph + 3'd1;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        logic [8:0] st;
        e  = q.pop_front();
        st = {sel, mem_rd, mem_wr, ld_ir, pc_inc, pc_load, acc_load, data_en, halt};
        n_checks++;
        assert (phase === e.ph) n_pass++;
        else $error("FAIL %s.phase observed=%0d expected=%0d", tag, phase, e.ph);
        n_checks++;
        assert (st === e.st) n_pass++;
        else $error("FAIL %s.strobes(ph%0d) observed=%b expected=%b", tag, e.ph, st, e.st);
        n_checks++;
        assert (pc_target === e.tgt) n_pass++;
        else $error("FAIL %s.pc_target observed=%0d expected=%0d", tag, pc_target, e.tgt);
        n_checks++;
        assert (opcode === e.op) n_pass++;
        else $error("FAIL %s.opcode observed=%0d expected=%0d", tag, opcode, e.op);
    endtask

    // Drive inputs, queue the prediction, clock once, then compare.
    task automatic cyc(input string tag, input logic en_v, input logic [7:0] rd_v, input logic az_v);
        en        = en_v;
        mem_rdata = rd_v;
        acc_zero  = az_v;
        model_step();
        q.push_back(expect_now());
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic run_instr(input string tag, input logic [7:0] instr, input logic az);
        for (int i = 0; i < 8; i++) cyc(tag, 1'b1, instr, az);
    endtask

    // Reset asserted between edges must act immediately.
    task automatic pulse_rst(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        q.push_back(expect_now());
        #1;
        pop_check(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mem_rdata = 8'h00;
        acc_zero  = 1'b0;
        resume    = 1'b0;
        model_reset();

        #2;
        q.push_back(expect_now());
        pop_check("reset");
        cyc("reset_hold", 1'b1, 8'hFF, 1'b1);
        cyc("reset_hold", 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_instr("lda", 8'hA3, 1'b0);
        run_instr("skz_taken", 8'h2A, 1'b1);
        run_instr("skz_not", 8'h2A, 1'b0);
        run_instr("jmp", 8'hF1, 1'b0);

        // STO with the enable dropped for three cycles in phase 5.
        for (int i = 0; i < 5; i++) cyc("sto", 1'b1, 8'hC4, 1'b0);
        for (int i = 0; i < 3; i++) cyc("sto_hold", 1'b0, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) cyc("sto", 1'b1, 8'hC4, 1'b0);

        // HLT: reach phase 4, then stay frozen.
        for (int i = 0; i < 4; i++) cyc("hlt", 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) cyc("hlt_frozen", 1'b1, 8'h00, 1'b1);
`ifdef CPU_CTRL_RESUME_EN
        resume = 1'b1;
        cyc("resume", 1'b1, 8'h00, 1'b0);
        resume = 1'b0;
        for (int i = 0; i < 3; i++) cyc("resume_run", 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cyc("hlt2", 1'b1, 8'h00, 1'b0);
`endif
        pulse_rst("hlt_rst");
        run_instr("after_hlt_add", 8'h47, 1'b0);

        // Reset while STO is asserting mem_wr in phase 7.
        for (int i = 0; i < 8; i++) cyc("sto_pre_rst", 1'b1, 8'hC9, 1'b0);
        for (int i = 0; i < 7; i++) cyc("sto_pre_rst", 1'b1, 8'hC9, 1'b0);
        pulse_rst("sto_rst");
        run_instr("xor", 8'h9F, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
